memory_access_stage: RTL

- Memory (M) stage of the 5-stage core.
- Sits between the execute/memory pipeline register (ED_* signals) and the memory/writeback register, which consumes M_valM_o.
- Issues loads and stores to the data bus over a req/ack handshake, aligns store data, and sign/zero-extends load data.
- Requests a pipeline stall while a bus access is outstanding.
- Holds a completed result while the pipeline is frozen by other hazards, so an access is never re-issued.

---
 rtl/memory_access_stage_pkg.sv | 46 ++++
 rtl/memory_access_stage_format.sv | 49 ++++
 rtl/memory_access_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared constants for the memory access stage: data width, RV32I load/store
// funct3 encodings, FSM state encoding and the access legality check.
package memory_access_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 1 when a load/store has an illegal funct3 or a misaligned address.
    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (rd) begin
            case (funct3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = lane[0];
                F3_LW:         bad = (lane != 2'b00);
                default:       bad = 1'b1;
            endcase
        end else if (wr) begin
            case (funct3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = lane[0];
                F3_SW:   bad = (lane != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_stage_format.sv
// Combinational data formatting: load lane extract with sign/zero extension,
// and store lane replication with byte-enable generation.
module mem_format
    import memory_access_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_val,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      be
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    always_comb begin
        shifted  = rdata >> {lane, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_val = {24'd0, byte_sel};
            F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_val = {16'd0, half_sel};
            default: load_val = rdata;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_SB: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << lane;
            end
            F3_SH: begin
                wdata = {2{store_data[15:0]}};
                be    = 4'b0011 << lane;
            end
            default: begin
                wdata = store_data;
                be    = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: issues loads/stores over a req/ack bus, stalls the pipeline
// while an access is outstanding and holds a finished result while frozen.
module memory_access_stage #(
    parameter int XLEN = memory_access_stage_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ED_mem_rd_i,
    input  logic            ED_mem_wr_i,
    input  logic [2:0]      ED_funct3_i,
    input  logic [XLEN-1:0] ED_valE_i,
    input  logic [XLEN-1:0] ED_valB_i,
    input  logic            M_stall_i,
    input  logic            M_flush_i,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    output logic [3:0]      dbus_be_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic [XLEN-1:0] M_valM_o,
    output logic            M_stall_req_o,
    output logic            M_fault_o
);
    import memory_access_stage_pkg::*;

    // Bus handshake: a request stays asserted with a stable payload until the
    // cycle dbus_ack_i is seen; that cycle completes the access.
    state_e          state_q, state_d;
    logic [XLEN-1:0] hold_q;
    logic            flushed_q;
    logic            access;
    logic            discard;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] fmt_wdata;
    logic [3:0]      fmt_be;
    logic [XLEN-1:0] result;

    mem_format u_fmt (
        .funct3     (ED_funct3_i),
        .lane       (ED_valE_i[1:0]),
        .rdata      (dbus_rdata_i),
        .store_data (ED_valB_i),
        .load_val   (load_val),
        .wdata      (fmt_wdata),
        .be         (fmt_be)
    );

    assign M_fault_o    = access_fault(ED_mem_rd_i, ED_mem_wr_i, ED_funct3_i, ED_valE_i[1:0]);
    assign access       = (ED_mem_rd_i | ED_mem_wr_i) & ~M_fault_o;
    assign dbus_we_o    = ED_mem_wr_i;
    assign dbus_addr_o  = {ED_valE_i[XLEN-1:2], 2'b00};
    assign dbus_wdata_o = fmt_wdata;
    assign dbus_be_o    = ED_mem_wr_i ? fmt_be : 4'b0000;
    assign result       = ED_mem_rd_i ? load_val : '0;
    // A flush seen at any point during BUSY throws the result away.
    assign discard      = flushed_q | M_flush_i;

    always_comb begin
        state_d       = state_q;
        dbus_req_o    = 1'b0;
        M_stall_req_o = 1'b0;
        M_valM_o      = '0;
        case (state_q)
            ST_IDLE: begin
                if (access && !M_flush_i) begin
                    dbus_req_o = 1'b1;
                    if (dbus_ack_i) begin
                        M_valM_o = result;
                        if (M_stall_i) state_d = ST_DONE;
                    end else begin
                        M_stall_req_o = 1'b1;
                        state_d       = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                dbus_req_o = 1'b1;
                if (dbus_ack_i) begin
                    if (!discard) M_valM_o = result;
                    state_d = (M_stall_i && !discard) ? ST_DONE : ST_IDLE;
                end else begin
                    M_stall_req_o = 1'b1;
                end
            end
            ST_DONE: begin
                M_valM_o = hold_q;
                if (!M_stall_i || M_flush_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst_i) begin
            dbus_req_o    = 1'b0;
            M_stall_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flushed_q <= (state_q == ST_BUSY) && (state_d == ST_BUSY) && discard;
            if (state_q != ST_DONE && state_d == ST_DONE) hold_q <= M_valM_o;
        end
    end

endmodule
